// File: rtl/baud_pkg.sv
// baud_pkg -- shared constants and elaboration-time helpers for the baud
// tick generator.
//   MIN_DIV       smallest integer divisor the counter supports
//   phase_w()     width of the oversample phase index
//   calc_def_int  reset-time integer divisor (truncated or rounded)
//   calc_def_frac reset-time fractional divisor (rounded remainder)
package baud_pkg;

  localparam int unsigned MIN_DIV = 32'd2;

  function automatic int unsigned phase_w(input int unsigned os);
    int unsigned w;
    if (os < 32'd2) begin
      w = 32'd1;
    end else begin
      w = $clog2(os);
    end
    return w;
  endfunction

  // Clocks per os_tick. Truncated when a fractional part carries the
  // remainder, rounded to nearest when it does not.
  function automatic longint unsigned calc_def_int(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned os,
    input bit              round_nearest
  );
    longint unsigned den;
    longint unsigned q;
    den = baud * os;
    if (den == 64'd0) begin
      den = 64'd1;
    end
    if (round_nearest) begin
      q = (clk_hz + den / 64'd2) / den;
    end else begin
      q = clk_hz / den;
    end
    if (q < 64'(MIN_DIV)) begin
      q = 64'(MIN_DIV);
    end
    return q;
  endfunction

  // Remainder of the truncated divisor in units of 1/2^frac_w, rounded and
  // saturated so it always fits the fractional register.
  function automatic longint unsigned calc_def_frac(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned os,
    input int unsigned     frac_w
  );
    longint unsigned den;
    longint unsigned rem;
    longint unsigned scale;
    longint unsigned f;
    den = baud * os;
    if (den == 64'd0) begin
      den = 64'd1;
    end
    rem   = clk_hz % den;
    scale = 64'd1 << frac_w;
    f     = (rem * scale + den / 64'd2) / den;
    if (f > scale - 64'd1) begin
      f = scale - 64'd1;
    end
    return f;
  endfunction

endpackage

// File: rtl/baud_frac_accum.sv
// baud_frac_accum -- FRAC_W-bit phase accumulator for the fractional divisor.
// Defined only when BAUD_FRAC_EN is set; the integer-only build needs no
// accumulator at all.
//   clk, rst_n  clock, asynchronous active-low reset
//   step        add addend into the accumulator (one os_tick reload)
//   clear       zero the accumulator (phase restart), wins over step
//   addend      fractional divisor used for this step
//   carry       carry-out of acc + addend, i.e. the extra clock this period
`ifdef BAUD_FRAC_EN
module baud_frac_accum
  import baud_pkg::*;
#(
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              clear,
  input  logic [FRAC_W-1:0] addend,
  output logic              carry
);

  logic [FRAC_W:0]   sum_s;
  logic [FRAC_W-1:0] acc_r;

  assign sum_s = {1'b0, acc_r} + {1'b0, addend};
  assign carry = sum_s[FRAC_W];

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {FRAC_W{1'b0}};
    end else if (clear) begin
      acc_r <= {FRAC_W{1'b0}};
    end else if (step) begin
      acc_r <= sum_s[FRAC_W-1:0];
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule
`endif

// File: rtl/baud_tick_gen.sv
// baud_tick_gen -- programmable UART baud tick generator.
// Produces a one-cycle oversample strobe every act_int(+frac) clocks and a
// bit strobe on every OVERSAMPLE-th oversample strobe. A new divisor is held
// pending and only swapped in at a period reload (or restart), so a running
// period is never cut short.
// Optional feature macro: BAUD_FRAC_EN (fractional divisor + accumulator).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  count enable (low freezes counters and phase)
//   restart             synchronous phase restart, beats a due tick
//   div_int/div_frac    requested divisor, captured by div_load
//   div_load            capture strobe; div_busy flags a pending value
//   os_tick, bit_tick   registered one-cycle strobes
//   os_phase            index of the last os_tick within the bit
//   act_int/act_frac    divisor currently in effect
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned FRAC_W       = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              restart,
  input  logic [DIV_W-1:0]                  div_int,
  input  logic [FRAC_W-1:0]                 div_frac,
  input  logic                              div_load,
  output logic                              div_busy,
  output logic                              os_tick,
  output logic                              bit_tick,
  output logic [phase_w(OVERSAMPLE)-1:0]    os_phase,
  output logic [DIV_W-1:0]                  act_int,
  output logic [FRAC_W-1:0]                 act_frac
);

`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  localparam int unsigned        PH_W      = phase_w(OVERSAMPLE);
  localparam logic [PH_W-1:0]    PH_LAST   = PH_W'(OVERSAMPLE - 32'd1);
  localparam logic [PH_W-1:0]    PH_ONE    = PH_W'(1'b1);
  localparam logic [DIV_W-1:0]   ONE_DIV   = DIV_W'(1'b1);
  localparam logic [DIV_W-1:0]   MIN_DIV_V = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0]   DEF_INT   = DIV_W'(calc_def_int(64'(CLK_HZ),
      64'(DEFAULT_BAUD), 64'(OVERSAMPLE), !FRAC_ON));

  logic [DIV_W-1:0] cnt_r, cnt_nxt_s;
  logic [DIV_W-1:0] act_int_r, act_int_nxt_s;
  logic [DIV_W-1:0] pend_int_r, pend_int_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic [PH_W-1:0]  phase_r, phase_nxt_s;
  logic             os_tick_r, os_tick_nxt_s;
  logic             bit_tick_r, bit_tick_nxt_s;

  logic [DIV_W-1:0] eff_int_s;
  logic [DIV_W-1:0] load_int_s;
  logic [DIV_W-1:0] reload_s;
  logic             tick_due_s;
  logic             apply_s;
  logic             carry_s;

  // The divisor that a reload at this cycle would use: pending wins if busy.
  assign eff_int_s  = busy_r ? pend_int_r : act_int_r;
  assign load_int_s = (div_int < MIN_DIV_V) ? MIN_DIV_V : div_int;
  assign tick_due_s = en & ~restart & (cnt_r == {DIV_W{1'b0}});
  assign apply_s    = busy_r & (restart | tick_due_s);
  // Modular arithmetic keeps int+carry-1 correct even when int is all ones.
  assign reload_s   = eff_int_s + DIV_W'(carry_s) - ONE_DIV;

`ifdef BAUD_FRAC_EN
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(calc_def_frac(64'(CLK_HZ),
      64'(DEFAULT_BAUD), 64'(OVERSAMPLE), FRAC_W));

  logic [FRAC_W-1:0] act_frac_r;
  logic [FRAC_W-1:0] pend_frac_r;
  logic [FRAC_W-1:0] eff_frac_s;

  assign eff_frac_s = busy_r ? pend_frac_r : act_frac_r;
  assign act_frac   = act_frac_r;

  baud_frac_accum #(
    .FRAC_W (FRAC_W)
  ) u_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (tick_due_s),
    .clear  (restart),
    .addend (eff_frac_s),
    .carry  (carry_s)
  );

  // Fractional divisor registers: promote pending on apply, capture on load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_frac_r  <= DEF_FRAC;
      pend_frac_r <= {FRAC_W{1'b0}};
    end else begin
      if (apply_s) begin
        act_frac_r <= pend_frac_r;
      end else begin
        act_frac_r <= act_frac_r;
      end
      if (div_load) begin
        pend_frac_r <= div_frac;
      end else begin
        pend_frac_r <= pend_frac_r;
      end
    end
  end
`else
  logic unused_frac_s;

  assign unused_frac_s = ^div_frac;
  assign carry_s       = 1'b0;
  assign act_frac      = {FRAC_W{1'b0}};
`endif

  // Next-state logic for counter, phase, strobes and integer divisor
  always_comb begin
    cnt_nxt_s      = cnt_r;
    phase_nxt_s    = phase_r;
    os_tick_nxt_s  = 1'b0;
    bit_tick_nxt_s = 1'b0;
    act_int_nxt_s  = act_int_r;
    pend_int_nxt_s = pend_int_r;
    busy_nxt_s     = busy_r;

    if (restart) begin
      cnt_nxt_s   = eff_int_s - ONE_DIV;
      phase_nxt_s = {PH_W{1'b0}};
    end else if (tick_due_s) begin
      cnt_nxt_s     = reload_s;
      os_tick_nxt_s = 1'b1;
      if (phase_r == PH_LAST) begin
        phase_nxt_s    = {PH_W{1'b0}};
        bit_tick_nxt_s = 1'b1;
      end else begin
        phase_nxt_s = phase_r + PH_ONE;
      end
    end else if (en) begin
      cnt_nxt_s = cnt_r - ONE_DIV;
    end else begin
      cnt_nxt_s = cnt_r;
    end

    // Apply first so a load in the same cycle becomes the next pending value.
    if (apply_s) begin
      act_int_nxt_s = pend_int_r;
      busy_nxt_s    = 1'b0;
    end else begin
      act_int_nxt_s = act_int_r;
    end

    if (div_load) begin
      pend_int_nxt_s = load_int_s;
      busy_nxt_s     = 1'b1;
    end else begin
      pend_int_nxt_s = pend_int_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= DEF_INT - ONE_DIV;
      act_int_r  <= DEF_INT;
      pend_int_r <= DEF_INT;
      busy_r     <= 1'b0;
      phase_r    <= {PH_W{1'b0}};
      os_tick_r  <= 1'b0;
      bit_tick_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      act_int_r  <= act_int_nxt_s;
      pend_int_r <= pend_int_nxt_s;
      busy_r     <= busy_nxt_s;
      phase_r    <= phase_nxt_s;
      os_tick_r  <= os_tick_nxt_s;
      bit_tick_r <= bit_tick_nxt_s;
    end
  end

  assign div_busy = busy_r;
  assign os_tick  = os_tick_r;
  assign bit_tick = bit_tick_r;
  assign os_phase = phase_r;
  assign act_int  = act_int_r;

endmodule

// File: tb/tb_baud_tick_gen.sv
`timescale 1ns/1ps
// Bench for baud_tick_gen: table of divisor loads checked against a queue of
// expected tick cycles, plus hand sequences for reset, mid-period change,
// enable freeze and restart collision.
module tb_baud_tick_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OS     = 16;
`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON  = 1'b1;
  localparam int DEF_INT  = 325;
  localparam int DEF_FRAC = 8;
`else
  localparam bit FRAC_ON  = 1'b0;
  localparam int DEF_INT  = 326;
  localparam int DEF_FRAC = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, en, restart, div_load;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_busy, os_tick, bit_tick;
  logic [3:0]        os_phase;
  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;

  baud_tick_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .restart  (restart),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .div_busy (div_busy),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .os_phase (os_phase),
    .act_int  (act_int),
    .act_frac (act_frac)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    bit bt;
    int ph;
  } exp_t;

  typedef struct {
    string name;
    int    di;
    int    df;
    int    exp_int;
    int    exp_frac;
    int    n;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;
  int   win_start = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected ticks: first at t0, then int + carry(acc + frac) with acc from 0.
  task automatic push_ticks(input int t0, input int di, input int df, input int n, input int ph0);
    int   t;
    int   acc;
    int   ph;
    exp_t e;
    t = t0; acc = 0; ph = ph0;
    for (int i = 0; i < n; i++) begin
      e.t  = t;
      e.bt = (ph == OS - 1);
      ph   = (ph == OS - 1) ? 0 : ph + 1;
      e.ph = ph;
      sb.push_back(e);
      t   = t + di + (((acc + df) >= (1 << FRAC_W)) ? 1 : 0);
      acc = (acc + df) % (1 << FRAC_W);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (sb.size() > 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk(name, sb.size(), 0);
    sb.delete();
    chk_en = 1'b0;
  endtask

  // Load a divisor, then restart so it applies at once; r = restart edge.
  task automatic load_restart(input int di, input int df, output int r);
    @(negedge clk);
    div_int  = DIV_W'(di);
    div_frac = FRAC_W'(df);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    chk("load_busy", div_busy, 1);
    r         = cyc + 1;
    win_start = r;
    chk_en    = 1'b1;
    restart   = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  // Scoreboard monitor: every observed or expected tick is one comparison.
  exp_t m_e;
  bit   m_hit;
  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n && cyc >= win_start) begin
      while (sb.size() > 0 && sb[0].t < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missed_tick: os_tick 0 at cycle %0d, expected 1", sb[0].t);
        m_e = sb.pop_front();
      end
      m_hit = (sb.size() > 0) && (sb[0].t == cyc);
      if (os_tick || bit_tick || m_hit) begin
        n_vec++;
        if (m_hit) begin
          m_e = sb.pop_front();
          if (os_tick !== 1'b1 || bit_tick !== m_e.bt || os_phase !== 4'(m_e.ph)) begin
            n_err++;
            $display("FAIL tick@%0d: got os=%0b bit=%0b ph=%0d expected os=1 bit=%0b ph=%0d",
                     cyc, os_tick, bit_tick, os_phase, m_e.bt, m_e.ph);
          end
        end else begin
          n_err++;
          $display("FAIL unexpected_tick@%0d: got os=%0b bit=%0b expected os=0 bit=0",
                   cyc, os_tick, bit_tick);
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int c;
    int t;
    rst_n = 1'b0; en = 1'b1; restart = 1'b0; div_load = 1'b0;
    div_int = '0; div_frac = '0;

    vecs[0] = '{"int4",    4, 0,  4, 0,                  40};
    vecs[1] = '{"frac4_8", 4, 8,  4, FRAC_ON ? 8 : 0,    32};
    vecs[2] = '{"clamp0",  0, 0,  2, 0,                  10};
    vecs[3] = '{"clamp1",  1, 3,  2, FRAC_ON ? 3 : 0,    10};
    vecs[4] = '{"int7f5",  7, 5,  7, FRAC_ON ? 5 : 0,    12};
    vecs[5] = '{"int5f15", 5, 15, 5, FRAC_ON ? 15 : 0,   12};

    // Reset values, then first tick DEF_INT edges after release
    repeat (3) @(negedge clk);
    chk("rst_os_tick", os_tick, 0);
    chk("rst_bit_tick", bit_tick, 0);
    chk("rst_phase", os_phase, 0);
    chk("rst_busy", div_busy, 0);
    chk("rst_act_int", act_int, DEF_INT);
    chk("rst_act_frac", act_frac, DEF_FRAC);
    c = cyc;
    rst_n = 1'b1;
    win_start = c + 1;
    chk_en = 1'b1;
    push_ticks(c + DEF_INT, DEF_INT, DEF_FRAC, 3, 0);
    drain("reset_release");

    // Table of divisor loads
    for (int i = 0; i < 6; i++) begin
      load_restart(vecs[i].di, vecs[i].df, r);
      chk({vecs[i].name, "_act_int"}, act_int, vecs[i].exp_int);
      chk({vecs[i].name, "_act_frac"}, act_frac, vecs[i].exp_frac);
      chk({vecs[i].name, "_busy"}, div_busy, 0);
      push_ticks(r + vecs[i].exp_int, vecs[i].exp_int, vecs[i].exp_frac, vecs[i].n, 0);
      drain({vecs[i].name, "_drain"});
    end

    // Two loads (6 then 3) inside a 4-cycle period: last one wins at reload
    load_restart(4, 0, r);
    push_ticks(r + 4, 3, 0, 5, 0);
    wait_until(r + 1);
    div_int = 16'd6; div_frac = 4'd0; div_load = 1'b1;
    wait_until(r + 2);
    div_int = 16'd3;
    wait_until(r + 3);
    div_load = 1'b0;
    chk("change_busy_hi", div_busy, 1);
    chk("change_act_old", act_int, 4);
    wait_until(r + 4);
    chk("change_busy_lo", div_busy, 0);
    chk("change_act_new", act_int, 3);
    drain("change_drain");

    // Enable low for 10 cycles at cnt=2; a load while frozen stays pending
    load_restart(3, 0, r);
    en = 1'b0;
    push_ticks(r + 13, 5, 0, 4, 0);
    wait_until(r + 3);
    div_int = 16'd5; div_frac = 4'd0; div_load = 1'b1;
    wait_until(r + 4);
    div_load = 1'b0;
    chk("freeze_busy", div_busy, 1);
    chk("freeze_act_hold", act_int, 3);
    wait_until(r + 10);
    en = 1'b1;
    wait_until(r + 13);
    chk("freeze_busy_lo", div_busy, 0);
    chk("freeze_act_new", act_int, 5);
    drain("freeze_drain");

    // Restart on the cycle a tick is due (period 5)
    t = -1;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (os_tick === 1'b1) begin
        t = cyc;
        break;
      end
    end
    chk("collide_found_tick", (t >= 0), 1);
    if (t >= 0) begin
      wait_until(t + 4);
      restart   = 1'b1;
      win_start = t + 5;
      chk_en    = 1'b1;
      push_ticks(t + 10, 5, 0, 3, 0);
      @(negedge clk);
      restart = 1'b0;
      chk("collide_no_tick", os_tick, 0);
      chk("collide_phase", os_phase, 0);
      drain("collide_drain");
    end

    // Reset mid-count with a load pending
    @(negedge clk);
    div_int = 16'd9; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    chk("prerst_busy", div_busy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_os_tick", os_tick, 0);
    chk("mrst_bit_tick", bit_tick, 0);
    chk("mrst_phase", os_phase, 0);
    chk("mrst_busy", div_busy, 0);
    chk("mrst_act_int", act_int, DEF_INT);
    chk("mrst_act_frac", act_frac, DEF_FRAC);
    @(negedge clk);
    c = cyc;
    rst_n = 1'b1;
    win_start = c + 1;
    chk_en = 1'b1;
    push_ticks(c + DEF_INT, DEF_INT, DEF_FRAC, 2, 0);
    drain("mrst_release");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
